// File: rtl/cp0_exc_sequencer.sv
// cp0_exc_sequencer
//   Sits between the commit stage and the CP0 register file. It picks one
//   event per cycle (exception, interrupt, ERET or MTC0) and owns the single
//   CP0 write port. Exceptions become a short sequence of writes: EPC, Cause,
//   optionally BadVAddr, then Status, followed by a one-cycle PC redirect.
//   Younger pipeline stages are flushed from the capture cycle through the
//   redirect.
//
//   Optional build macro: CP0_INT_SYNC_EN
//     defined   : hw_int goes through a two-flop synchroniser (2-cycle latency)
//     undefined : hw_int goes through a single register stage (1-cycle latency)
//
//   Cause and Status write values are built from cause_in/status_in as they
//   are in the capture cycle, so the sequence is self-consistent even if
//   those inputs move while the writes are in flight.
module cp0_exc_sequencer #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             exc_bd,
  input  logic [WIDTH-1:0] exc_badvaddr,
  input  logic             eret_valid,
  input  logic             commit_valid,
  input  logic [WIDTH-1:0] commit_pc,
  input  logic             commit_bd,
  input  logic [5:0]       hw_int,
  input  logic [WIDTH-1:0] status_in,
  input  logic [WIDTH-1:0] cause_in,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             mtc0_valid,
  input  logic [4:0]       mtc0_addr,
  input  logic [WIDTH-1:0] mtc0_data,
  output logic             mtc0_ready,
  output logic [31:0]      cp0_we,
  output logic             cp0_gwe,
  output logic [4:0]       cp0_waddr,
  output logic [WIDTH-1:0] cp0_wdata,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             busy
);

  localparam logic [4:0] REG_BADV   = 5'd8;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_EPC    = 3'd1,
    S_WR_CAUSE  = 3'd2,
    S_WR_BADV   = 3'd3,
    S_WR_STATUS = 3'd4,
    S_REDIRECT  = 3'd5,
    S_MTC0      = 3'd6
  } state_e;

  state_e state_q, state_d;

  // Control flops (reset)
  logic             has_badv_q, has_badv_d;
  logic [5:0]       hw_sync_q, hw_sync_d;

  // Captured data (no reset; only read in states entered after a capture)
  logic [WIDTH-1:0] epc_val_q, epc_val_d;
  logic [WIDTH-1:0] cause_val_q, cause_val_d;
  logic [WIDTH-1:0] badv_q, badv_d;
  logic [WIDTH-1:0] status_val_q, status_val_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [4:0]       mtc0_waddr_q, mtc0_waddr_d;
  logic [WIDTH-1:0] mtc0_wdata_q, mtc0_wdata_d;

  // Capture-cycle selection between the exception and the interrupt source
  logic [4:0]       cap_code;
  logic [WIDTH-1:0] cap_pc;
  logic             cap_bd;
  logic [7:0]       ip;
  logic             int_pend;
  logic             take_exc;

  // Only these Cause fields feed the new Cause value
  logic unused_cause_bits;
  assign unused_cause_bits = ^{cause_in[31], cause_in[15:10], cause_in[7:0]};

  function automatic logic [31:0] reg_bit(input logic [4:0] addr);
    reg_bit = 32'd1 << addr;
  endfunction

`ifdef CP0_INT_SYNC_EN
  logic [5:0] hw_meta_q, hw_meta_d;

  // Two-flop synchroniser input path for the external interrupt lines
  always_comb begin
    hw_meta_d = hw_int;
    hw_sync_d = hw_meta_q;
  end

  // Synchroniser flops, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_meta_q <= '0;
      hw_sync_q <= '0;
    end else begin
      hw_meta_q <= hw_meta_d;
      hw_sync_q <= hw_sync_d;
    end
  end
`else
  // Single register stage on the external interrupt lines
  always_comb begin
    hw_sync_d = hw_int;
  end

  // Interrupt register, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_sync_q <= '0;
    end else begin
      hw_sync_q <= hw_sync_d;
    end
  end
`endif

  assign ip       = {hw_sync_q, cause_in[9:8]};
  assign int_pend = status_in[0] & ~status_in[1] & (|(ip & status_in[15:8]));
  assign take_exc = exc_valid | (int_pend & commit_valid);
  assign busy     = (state_q != S_IDLE);

  // Exception source wins over the interrupt; interrupts report code 0
  always_comb begin
    cap_code = exc_code;
    cap_pc   = exc_pc;
    cap_bd   = exc_bd;
    if (!exc_valid) begin
      cap_code = 5'd0;
      cap_pc   = commit_pc;
      cap_bd   = commit_bd;
    end
  end

  // Arbitration, capture, next state and CP0 write-port outputs
  always_comb begin
    state_d        = state_q;
    has_badv_d     = has_badv_q;
    epc_val_d      = epc_val_q;
    cause_val_d    = cause_val_q;
    badv_d         = badv_q;
    status_val_d   = status_val_q;
    target_d       = target_q;
    mtc0_waddr_d   = mtc0_waddr_q;
    mtc0_wdata_d   = mtc0_wdata_q;
    mtc0_ready     = 1'b0;
    cp0_we         = '0;
    cp0_gwe        = 1'b0;
    cp0_waddr      = '0;
    cp0_wdata      = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state_q)
      S_IDLE: begin
        // Reset gates the combinational capture outputs as well
        if (!rst) begin
          if (take_exc) begin
            flush        = 1'b1;
            epc_val_d    = cap_bd ? (cap_pc - WIDTH'(4)) : cap_pc;
            cause_val_d  = {cap_bd, cause_in[30:16], hw_sync_q, cause_in[9:8],
                            1'b0, cap_code, 2'b00};
            badv_d       = exc_badvaddr;
            has_badv_d   = (cap_code == 5'd4) || (cap_code == 5'd5);
            status_val_d = status_in | WIDTH'(2);
            target_d     = EXC_VECTOR;
            // A nested exception (EXL already set) keeps the original EPC
            state_d      = status_in[1] ? S_WR_CAUSE : S_WR_EPC;
          end else if (eret_valid) begin
            flush        = 1'b1;
            has_badv_d   = 1'b0;
            status_val_d = status_in & ~WIDTH'(2);
            target_d     = epc_in;
            state_d      = S_WR_STATUS;
          end else if (mtc0_valid) begin
            mtc0_ready   = 1'b1;
            mtc0_waddr_d = mtc0_addr;
            mtc0_wdata_d = mtc0_data;
            state_d      = S_MTC0;
          end
        end
      end
      S_WR_EPC: begin
        flush     = 1'b1;
        cp0_we    = reg_bit(REG_EPC);
        cp0_waddr = REG_EPC;
        cp0_wdata = epc_val_q;
        state_d   = S_WR_CAUSE;
      end
      S_WR_CAUSE: begin
        flush     = 1'b1;
        cp0_we    = reg_bit(REG_CAUSE);
        cp0_waddr = REG_CAUSE;
        cp0_wdata = cause_val_q;
        state_d   = has_badv_q ? S_WR_BADV : S_WR_STATUS;
      end
      S_WR_BADV: begin
        flush     = 1'b1;
        cp0_we    = reg_bit(REG_BADV);
        cp0_waddr = REG_BADV;
        cp0_wdata = badv_q;
        state_d   = S_WR_STATUS;
      end
      S_WR_STATUS: begin
        flush     = 1'b1;
        cp0_we    = reg_bit(REG_STATUS);
        cp0_waddr = REG_STATUS;
        cp0_wdata = status_val_q;
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = S_IDLE;
      end
      S_MTC0: begin
        cp0_gwe   = 1'b1;
        cp0_waddr = mtc0_waddr_q;
        cp0_wdata = mtc0_wdata_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      has_badv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      has_badv_q <= has_badv_d;
    end
  end

  // Captured write values and redirect target
  always_ff @(posedge clk) begin
    epc_val_q    <= epc_val_d;
    cause_val_q  <= cause_val_d;
    badv_q       <= badv_d;
    status_val_q <= status_val_d;
    target_q     <= target_d;
    mtc0_waddr_q <= mtc0_waddr_d;
    mtc0_wdata_q <= mtc0_wdata_d;
  end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Testbench for cp0_exc_sequencer: directed scenarios followed by random
// traffic, all checked cycle by cycle against a list-based reference model.
module tb_cp0_exc_sequencer;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
`ifdef CP0_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic [5:0]  hw_int;
  logic [31:0] status_in;
  logic [31:0] cause_in;
  logic [31:0] epc_in;
  logic        mtc0_valid;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        mtc0_ready;
  logic [31:0] cp0_we;
  logic        cp0_gwe;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  cp0_exc_sequencer dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret_valid(eret_valid),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
    .hw_int(hw_int), .status_in(status_in), .cause_in(cause_in), .epc_in(epc_in),
    .mtc0_valid(mtc0_valid), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mtc0_ready(mtc0_ready), .cp0_we(cp0_we), .cp0_gwe(cp0_gwe),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] we;
    logic        gwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic        ready;
  } exp_t;

  exp_t        pend[$];
  logic [5:0]  hw_h1, hw_h2;
  int          total, passed, failed;
  logic        o_flush, o_rv, o_busy, o_ready;
  logic [31:0] o_we, last_rv_pc;
  int          wl_addr[$];
  logic [31:0] wl_data[$];
  int          gwe_cnt;
  logic [4:0]  codes [7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e = '0;
    e.we[a] = 1'b1;
    e.waddr = a;
    e.wdata = d;
    e.flush = 1'b1;
    e.busy  = 1'b1;
    return e;
  endfunction

  function automatic exp_t redir(input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.flush = 1'b1;
    e.rv    = 1'b1;
    e.rpc   = pc;
    e.busy  = 1'b1;
    return e;
  endfunction

  task automatic push_exception(input logic [4:0] code, input logic [31:0] pc,
                                input logic bd, input logic [31:0] bva,
                                input logic [5:0] hwv);
    logic [31:0] c;
    c = '0;
    c[31]    = bd;
    c[30:16] = cause_in[30:16];
    c[15:10] = hwv;
    c[9:8]   = cause_in[9:8];
    c[6:2]   = code;
    if (!status_in[1]) pend.push_back(wr(5'd14, bd ? pc - 32'd4 : pc));
    pend.push_back(wr(5'd13, c));
    if (code == 5'd4 || code == 5'd5) pend.push_back(wr(5'd8, bva));
    pend.push_back(wr(5'd12, status_in | 32'h2));
    pend.push_back(redir(EXC_VEC));
  endtask

  task automatic model_eval(output exp_t e, output bit was_busy);
    logic [5:0] hwv;
    logic [7:0] ipv;
    bit         ipend;
    exp_t       r;
    e        = '0;
    was_busy = (pend.size() != 0);
    hwv      = (SYNC_LAT == 2) ? hw_h2 : hw_h1;
    ipv      = {hwv, cause_in[9:8]};
    ipend    = 1'b0;
    for (int i = 0; i < 8; i++) if (ipv[i] && status_in[8+i]) ipend = 1'b1;
    ipend = ipend && status_in[0] && !status_in[1];
    if (rst) begin
      e = '0;
    end else if (was_busy) begin
      e = pend[0];
    end else if (exc_valid) begin
      e.flush = 1'b1;
      push_exception(exc_code, exc_pc, exc_bd, exc_badvaddr, hwv);
    end else if (ipend && commit_valid) begin
      e.flush = 1'b1;
      push_exception(5'd0, commit_pc, commit_bd, 32'd0, hwv);
    end else if (eret_valid) begin
      e.flush = 1'b1;
      pend.push_back(wr(5'd12, status_in & ~32'h2));
      pend.push_back(redir(epc_in));
    end else if (mtc0_valid) begin
      e.ready = 1'b1;
      r       = '0;
      r.gwe   = 1'b1;
      r.waddr = mtc0_addr;
      r.wdata = mtc0_data;
      r.busy  = 1'b1;
      pend.push_back(r);
    end
  endtask

  task automatic model_advance(input bit was_busy);
    if (rst) begin
      pend.delete();
      hw_h1 = '0;
      hw_h2 = '0;
    end else begin
      if (was_busy) void'(pend.pop_front());
      hw_h2 = hw_h1;
      hw_h1 = hw_int;
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model
  task automatic step();
    exp_t e;
    bit   wb;
    #1;
    model_eval(e, wb);
    chk("cp0_we", cp0_we, e.we);
    chk("cp0_gwe", 32'(cp0_gwe), 32'(e.gwe));
    chk("cp0_waddr", 32'(cp0_waddr), 32'(e.waddr));
    chk("cp0_wdata", cp0_wdata, e.wdata);
    chk("flush", 32'(flush), 32'(e.flush));
    chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
    chk("redirect_pc", redirect_pc, e.rpc);
    chk("busy", 32'(busy), 32'(e.busy));
    chk("mtc0_ready", 32'(mtc0_ready), 32'(e.ready));
    o_flush = flush;
    o_rv    = redirect_valid;
    o_busy  = busy;
    o_ready = mtc0_ready;
    o_we    = cp0_we;
    if (redirect_valid) last_rv_pc = redirect_pc;
    if (cp0_we != 32'd0) begin
      wl_addr.push_back(int'(cp0_waddr));
      wl_data.push_back(cp0_wdata);
    end
    if (cp0_gwe) gwe_cnt++;
    @(posedge clk);
    model_advance(wb);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    exc_valid    = 1'b0;
    eret_valid   = 1'b0;
    commit_valid = 1'b0;
    mtc0_valid   = 1'b0;
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
    gwe_cnt    = 0;
    last_rv_pc = '0;
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] pc,
                         input logic bd, input logic [31:0] bva);
    exc_valid    = 1'b1;
    exc_code     = code;
    exc_pc       = pc;
    exc_bd       = bd;
    exc_badvaddr = bva;
  endtask

  // Capture in the first cycle, then n-1 quiet cycles
  task automatic run_capture(input int n, output int rv_off, output int nflush);
    clear_log();
    rv_off = -1;
    nflush = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) idle_inputs();
      if (o_flush) nflush++;
      if (o_rv && rv_off < 0) rv_off = i;
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input int a, input logic [31:0] d);
    chk({tag, "_addr"}, (idx < wl_addr.size()) ? 32'(wl_addr[idx]) : 32'hFFFFFFFF, 32'(a));
    chk({tag, "_data"}, (idx < wl_data.size()) ? wl_data[idx] : 32'hDEADBEEF, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv, nf, cap, acc, rvcnt;
    total = 0; passed = 0; failed = 0;
    hw_h1 = '0; hw_h2 = '0;
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    rst = 1'b1;
    idle_inputs();
    exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_badvaddr = '0;
    commit_pc = '0; commit_bd = 1'b0; hw_int = '0;
    status_in = '0; cause_in = '0; epc_in = '0;
    mtc0_addr = '0; mtc0_data = '0;
    clear_log();
    @(negedge clk);
    step();
    step();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_flush", 32'(o_flush), 32'd0);
    chk("rst_we", o_we, 32'd0);
    chk("rst_redirect", 32'(o_rv), 32'd0);
    rst = 1'b0;
    step();
    step();

    // T1: Ov exception
    status_in = 32'h0000FF01; cause_in = '0; hw_int = '0;
    set_exc(5'd12, 32'h80001000, 1'b0, 32'h0);
    run_capture(8, rv, nf);
    chk("t1_nwr", 32'(wl_addr.size()), 32'd3);
    chk_wr("t1_epc", 0, 14, 32'h80001000);
    chk_wr("t1_cause", 1, 13, 32'h00000030);
    chk_wr("t1_status", 2, 12, 32'h0000FF03);
    chk("t1_redirect_off", 32'(rv), 32'd4);
    chk("t1_redirect_pc", last_rv_pc, 32'hBFC00380);
    chk("t1_flush_cycles", 32'(nf), 32'd5);

    // T2: AdEL in a delay slot
    set_exc(5'd4, 32'h80002004, 1'b1, 32'h00000003);
    run_capture(8, rv, nf);
    chk("t2_nwr", 32'(wl_addr.size()), 32'd4);
    chk_wr("t2_epc", 0, 14, 32'h80002000);
    chk_wr("t2_cause", 1, 13, 32'h80000010);
    chk_wr("t2_badv", 2, 8, 32'h00000003);
    chk_wr("t2_status", 3, 12, 32'h0000FF03);
    chk("t2_redirect_off", 32'(rv), 32'd5);

    // T3: external interrupt through the synchroniser
    clear_log();
    hw_int = 6'b000001; commit_valid = 1'b1; commit_pc = 32'h80003000; commit_bd = 1'b0;
    cap = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_flush) begin
        cap = i;
        break;
      end
    end
    chk("t3_sync_latency", 32'(cap), 32'(SYNC_LAT));
    idle_inputs();
    repeat (7) step();
    chk_wr("t3_epc", 0, 14, 32'h80003000);
    chk_wr("t3_cause", 1, 13, 32'h00000400);
    hw_int = '0;
    repeat (3) step();

    // T4: nested exception (EXL already set)
    status_in = 32'h0000FF03;
    set_exc(5'd8, 32'h80004000, 1'b0, 32'h0);
    run_capture(8, rv, nf);
    chk("t4_nwr", 32'(wl_addr.size()), 32'd2);
    chk_wr("t4_cause", 0, 13, 32'h00000020);
    chk_wr("t4_status", 1, 12, 32'h0000FF03);
    chk("t4_redirect_off", 32'(rv), 32'd3);

    // T5: ERET and MTC0 together
    clear_log();
    epc_in = 32'h80005000;
    eret_valid = 1'b1; mtc0_valid = 1'b1; mtc0_addr = 5'd11; mtc0_data = 32'h12345678;
    step();
    chk("t5_ready_at_capture", 32'(o_ready), 32'd0);
    chk("t5_flush_at_capture", 32'(o_flush), 32'd1);
    eret_valid = 1'b0;
    acc = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_ready && acc < 0) begin
        acc = i;
        mtc0_valid = 1'b0;
      end
    end
    chk_wr("t5_status", 0, 12, 32'h0000FF01);
    chk("t5_redirect_pc", last_rv_pc, 32'h80005000);
    chk("t5_mtc0_accept", 32'(acc), 32'd2);
    chk("t5_gwe_pulses", 32'(gwe_cnt), 32'd1);

    // T6: reset in WR_CAUSE
    status_in = 32'h0000FF01;
    set_exc(5'd12, 32'h80006000, 1'b0, 32'h0);
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_we", cp0_we, 32'd0);
    chk("t6_flush", 32'(flush), 32'd0);
    chk("t6_redirect", 32'(redirect_valid), 32'd0);
    step();
    rst = 1'b0;
    rvcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_rv) rvcnt++;
    end
    chk("t6_no_redirect", 32'(rvcnt), 32'd0);

    // PC wrap on a delay-slot exception at address 0
    set_exc(5'd12, 32'h00000000, 1'b1, 32'h0);
    run_capture(8, rv, nf);
    chk_wr("wrap_epc", 0, 14, 32'hFFFFFFFC);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      exc_valid    = ($urandom_range(0, 9) == 0);
      exc_code     = codes[$urandom_range(0, 6)];
      exc_pc       = $urandom;
      exc_bd       = $urandom_range(0, 1) == 1;
      exc_badvaddr = $urandom;
      eret_valid   = ($urandom_range(0, 9) == 0);
      commit_valid = $urandom_range(0, 1) == 1;
      commit_pc    = $urandom;
      commit_bd    = $urandom_range(0, 1) == 1;
      epc_in       = $urandom;
      mtc0_valid   = ($urandom_range(0, 3) == 0);
      mtc0_addr    = 5'($urandom);
      mtc0_data    = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
      if (pend.size() == 0) begin
        status_in = {24'($urandom), 6'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 7) != 0)};
        cause_in  = $urandom;
      end
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (8) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
